// File: rtl/alu_seq_driver.sv
// Initiator for a combinational ALU: takes ADD/INC/LOOP commands, drives the ALU and returns its results.
// Optional ALU_SEQ_BYPASS_EN lets a new command be accepted on the same edge that the response is consumed.
module alu_seq_driver #(
  parameter int DATAW     = 32,
  parameter int MAX_ITERS = 1024,
  parameter int CNTW      = $clog2(MAX_ITERS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [DATAW-1:0] cmd_a,
  input  logic [DATAW-1:0] cmd_b,
  output logic [DATAW-1:0] alu_a,
  output logic [DATAW-1:0] alu_b,
  output logic             alu_op,
  input  logic [DATAW-1:0] alu_out,
  input  logic             p_flag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DATAW-1:0] rsp_data,
  output logic             rsp_pflag,
  output logic [CNTW-1:0]  rsp_iters,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; the
  // sender holds its payload stable while valid is high and ready is low.

  localparam logic [1:0]      OP_INC  = 2'b01;
  localparam logic [1:0]      OP_LOOP = 2'b10;
  localparam logic [CNTW-1:0] CAP     = CNTW'(MAX_ITERS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_LOOP = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t           r_state;
  logic [DATAW-1:0] r_alu_a;
  logic [DATAW-1:0] r_alu_b;
  logic             r_alu_op;
  logic             r_rsp_valid;
  logic [DATAW-1:0] r_rsp_data;
  logic             r_rsp_pflag;
  logic [CNTW-1:0]  r_rsp_iters;
  logic [CNTW-1:0]  r_count;
  logic             w_cmd_ready;
  logic             w_accept;

`ifdef ALU_SEQ_BYPASS_EN
  assign w_cmd_ready = (r_state == S_IDLE) || ((r_state == S_RESP) && rsp_ready);
`else
  assign w_cmd_ready = (r_state == S_IDLE);
`endif

  assign w_accept = cmd_valid && w_cmd_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_pflag <= 1'b0;
      r_rsp_iters <= '0;
      r_count     <= '0;
    end else begin
      case (r_state)
        S_EXEC: begin
          r_rsp_data  <= alu_out;
          r_rsp_pflag <= p_flag;
          r_rsp_iters <= '0;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_LOOP: begin
          // Bound exceeded wins over the iteration cap when both hold together.
          if (p_flag) begin
            r_rsp_data  <= r_alu_a;
            r_rsp_pflag <= 1'b1;
            r_rsp_iters <= r_count;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else if (r_count == CAP) begin
            r_rsp_data  <= r_alu_a;
            r_rsp_pflag <= 1'b0;
            r_rsp_iters <= CAP;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_alu_a <= alu_out;
            r_count <= r_count + CNTW'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
        end
      endcase

      // Placed after the case so a bypass accept in RESP overrides the return to IDLE.
      if (w_accept) begin
        r_alu_a  <= cmd_a;
        r_alu_b  <= cmd_b;
        r_count  <= '0;
        r_alu_op <= (cmd_op == OP_INC) || (cmd_op == OP_LOOP);
        r_state  <= (cmd_op == OP_LOOP) ? S_LOOP : S_EXEC;
      end
    end
  end

  assign cmd_ready = w_cmd_ready;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_op    = r_alu_op;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_pflag = r_rsp_pflag;
  assign rsp_iters = r_rsp_iters;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_alu_seq_driver.sv
// Bench for alu_seq_driver: ALU stand-in, directed commands, and a per-cycle reference-model compare.
// Honours ALU_SEQ_BYPASS_EN when the design is built with it.
module tb_alu_seq_driver;

  localparam int DATAW = 32;
  localparam int MAXI  = 16;
  localparam int CNTW  = 5;

  localparam logic [1:0] ADD  = 2'b00;
  localparam logic [1:0] INC  = 2'b01;
  localparam logic [1:0] LOOP = 2'b10;
  localparam logic [1:0] RSV  = 2'b11;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [DATAW-1:0] cmd_a;
  logic [DATAW-1:0] cmd_b;
  logic [DATAW-1:0] alu_a;
  logic [DATAW-1:0] alu_b;
  logic             alu_op;
  logic [DATAW-1:0] alu_out;
  logic             p_flag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [DATAW-1:0] rsp_data;
  logic             rsp_pflag;
  logic [CNTW-1:0]  rsp_iters;
  logic [1:0]       dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit started = 1'b0;

  // Expected responses, one entry per accepted command not yet consumed.
  logic [DATAW-1:0] exp_q[$];
  logic             exp_p_q[$];
  logic [CNTW-1:0]  exp_it_q[$];
  int               due_q[$];

  // ---------------- clock / reset / DUT ----------------
  always #5 clk = ~clk;

  alu_seq_driver #(.DATAW(DATAW), .MAX_ITERS(MAXI)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .p_flag(p_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_pflag(rsp_pflag), .rsp_iters(rsp_iters),
    .dbg_state(dbg_state)
  );

  // Combinational ALU living outside the DUT.
  assign alu_out = alu_op ? (alu_a + 32'd1) : (alu_a + alu_b);
  assign p_flag  = alu_op ? (alu_a > alu_b) : ((alu_a + alu_b) != 32'd0);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model(input logic [1:0] op, input logic [DATAW-1:0] a, input logic [DATAW-1:0] b,
                       output logic [DATAW-1:0] d, output logic p, output int n);
    logic [DATAW-1:0] cur;
    n = 0;
    if (op == LOOP) begin
      cur = a;
      while (n < MAXI && !(cur > b)) begin
        cur = cur + 32'd1;
        n++;
      end
      d = cur;
      p = (cur > b);
    end else if (op == INC) begin
      d = a + 32'd1;
      p = (a > b);
    end else begin
      d = a + b;
      p = (d != 32'd0);
    end
  endtask

  // Edge monitor: retires consumed responses and predicts new ones.
  always @(posedge clk) begin
    logic [DATAW-1:0] d;
    logic             p;
    int               n;
    cyc++;
    if (rst) begin
      started = 1'b1;
      exp_q.delete(); exp_p_q.delete(); exp_it_q.delete(); due_q.delete();
    end else if (started) begin
      if (rsp_valid && rsp_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front()); void'(exp_p_q.pop_front());
        void'(exp_it_q.pop_front()); void'(due_q.pop_front());
      end
      if (cmd_valid && cmd_ready) begin
        model(cmd_op, cmd_a, cmd_b, d, p, n);
        exp_q.push_back(d);
        exp_p_q.push_back(p);
        exp_it_q.push_back(CNTW'(n));
        // Response visible after edge (accept + 1 + iterations).
        due_q.push_back(cyc + 1 + n);
      end
    end
  end

  // Per-cycle compare, just after the edge.
  always @(posedge clk) begin
    bit exp_valid;
    bit exp_ready;
    #1;
    if (started) begin
      exp_valid = (exp_q.size() > 0) && (cyc >= due_q[0]);
`ifdef ALU_SEQ_BYPASS_EN
      exp_ready = (exp_q.size() == 0) || (exp_valid && rsp_ready);
`else
      exp_ready = (exp_q.size() == 0);
`endif
      chk("rsp_valid", rsp_valid, exp_valid);
      chk("cmd_ready", cmd_ready, exp_ready);
      if (exp_valid) begin
        chk("rsp_data", rsp_data, exp_q[0]);
        chk("rsp_pflag", rsp_pflag, exp_p_q[0]);
        chk("rsp_iters", rsp_iters, exp_it_q[0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [1:0] op, input logic [DATAW-1:0] a, input logic [DATAW-1:0] b,
                      output int acc);
    bit took;
    int n;
    took = 1'b0;
    n = 0;
    acc = -1;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    while (!took && n < 200) begin
      @(posedge clk);
      took = cmd_ready;
      @(negedge clk);
      n++;
      if (took) acc = cyc;
    end
    cmd_valid = 1'b0;
    if (!took) chk("accept_timeout", 0, 1);
  endtask

  task automatic get_rsp(input int acc, output logic [DATAW-1:0] d, output logic p,
                         output logic [CNTW-1:0] it, output int lat);
    int n;
    n = 0;
    rsp_ready = 1'b1;
    while (!rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) chk("rsp_timeout", 0, 1);
    d = rsp_data; p = rsp_pflag; it = rsp_iters;
    // Edge at which rsp_valid is first sampled high, relative to the accept edge.
    lat = cyc + 1 - acc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input string name, input logic [1:0] op, input logic [DATAW-1:0] a,
                     input logic [DATAW-1:0] b, input logic [DATAW-1:0] ed, input logic ep,
                     input int eit, input int elat);
    int acc, lat;
    logic [DATAW-1:0] d;
    logic p;
    logic [CNTW-1:0] it;
    send(op, a, b, acc);
    get_rsp(acc, d, p, it, lat);
    chk({name, "_data"}, d, ed);
    chk({name, "_pflag"}, p, ep);
    chk({name, "_iters"}, it, eit);
    if (elat > 0) chk({name, "_lat"}, lat, elat);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int acc, hs, lat;
    logic [DATAW-1:0] d;
    logic p;
    logic [CNTW-1:0] it;

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = ADD; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_pflag", rsp_pflag, 0);
    chk("rst_rsp_iters", rsp_iters, 0);

    run("add_3_4", ADD, 32'd3, 32'd4, 32'd7, 1'b1, 0, 2);
    run("add_0_0", ADD, 32'd0, 32'd0, 32'd0, 1'b0, 0, 2);
    run("inc_wrap", INC, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b1, 0, 2);
    run("inc_le", INC, 32'd4, 32'd9, 32'd5, 1'b0, 0, 2);
    run("rsv_add", RSV, 32'd10, 32'd20, 32'd30, 1'b1, 0, 2);
    run("add_wrap", ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 0, 2);
    run("loop_5_8", LOOP, 32'd5, 32'd8, 32'd9, 1'b1, 4, 6);
    run("loop_9_8", LOOP, 32'd9, 32'd8, 32'd9, 1'b1, 0, 2);
    run("loop_cap", LOOP, 32'd0, 32'hFFFF_FFFF, 32'd16, 1'b0, 16, 18);
    run("loop_top", LOOP, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1, 1, 3);
    run("loop_edge", LOOP, 32'd0, 32'd15, 32'd16, 1'b1, 16, 18);

    // Back-pressure: response held for 10+ cycles, then a queued ADD.
    rsp_ready = 1'b0;
    send(ADD, 32'd1, 32'd2, acc);
    repeat (12) @(negedge clk);
    chk("hold_valid", rsp_valid, 1);
    chk("hold_data", rsp_data, 3);
    chk("hold_cmd_ready", cmd_ready, 0);
    rsp_ready = 1'b1;
    hs = cyc + 1;
    send(ADD, 32'd5, 32'd6, acc);
`ifdef ALU_SEQ_BYPASS_EN
    chk("bypass_accept_edge", acc, hs);
`else
    chk("accept_edge", acc, hs + 1);
`endif
    get_rsp(acc, d, p, it, lat);
    chk("queued_add_data", d, 11);
    chk("queued_add_lat", lat, 2);

    // Reset in the middle of a LOOP.
    send(LOOP, 32'd0, 32'd100, acc);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_cmd_ready", cmd_ready, 1);
    chk("midrst_alu_a", alu_a, 0);
    run("post_rst_add", ADD, 32'd1, 32'd1, 32'd2, 1'b1, 0, 2);

    repeat (3) @(negedge clk);
    chk("drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
